// File: rtl/fp16_host_pkg.sv
// Shared types and FP16 field constants for the byte-serial FP16 multiplier host.
package fp16_host_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StSendLo,
    StSendHi,
    StWait,
    StRecvLo,
    StRecvHi,
    StResp
  } host_state_e;

  localparam int unsigned SIGN_BIT = 15;
  localparam int unsigned EXP_MSB  = 14;
  localparam int unsigned EXP_LSB  = 10;
  localparam int unsigned MANT_W   = 10;
  localparam int unsigned EXP_W    = EXP_MSB - EXP_LSB + 1;
  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned BYTES    = 2;

  // The device is enabled from the sync cycle through the last receive cycle.
  function automatic logic dev_active(host_state_e s);
    return (s != StIdle) && (s != StResp);
  endfunction

endpackage

// File: rtl/fp16_mul_ref.sv
// Combinational reference of the device's simplified FP16 multiply, used to flag bad results.
module fp16_mul_ref
  import fp16_host_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] prod
);

  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb, e;
  logic [MANT_W-1:0] ma, mb, mant;
  logic [MANT_W:0]   m;
  logic              c;

  always_comb begin
    sa   = a[SIGN_BIT];
    sb   = b[SIGN_BIT];
    ea   = a[EXP_MSB:EXP_LSB];
    eb   = b[EXP_MSB:EXP_LSB];
    ma   = a[MANT_W-1:0];
    mb   = b[MANT_W-1:0];
    // Hidden-one sum wraps at 11 bits; bit 10 is the normalisation carry.
    m    = {1'b1, ma} + {1'b1, mb};
    c    = m[MANT_W];
    e    = ea + eb - EXP_W'(EXP_BIAS) + {{(EXP_W-1){1'b0}}, c};
    mant = c ? m[MANT_W:1] : m[MANT_W-1:0];
    prod = {sa ^ sb, e, mant};
  end

endmodule

// File: rtl/fp16_mul_byte_host.sv
// Host initiator for the byte-serial FP16 multiplier: serialises an operand pair, returns result.
// Optional reference check enabled by defining FP16_HOST_REF_CHECK_EN.
module fp16_mul_byte_host
  import fp16_host_pkg::*;
#(
  parameter int unsigned RESP_LAT = 3,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              dev_ena,
  output logic [7:0]        dev_ui,
  output logic [7:0]        dev_uio,
  input  logic [7:0]        dev_uo,
  output logic              chk_mismatch
);

  host_state_e       state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              dev_ena_q, dev_ena_d;
  logic [7:0]        dev_ui_q, dev_ui_d;
  logic [7:0]        dev_uio_q, dev_uio_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          a_d     = req_a;
          b_d     = req_b;
          state_d = StSync;
        end
      end
      StSync:   state_d = StSendLo;
      StSendLo: state_d = StSendHi;
      StSendHi: begin
        cnt_d   = 4'(RESP_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StRecvLo;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRecvLo: begin
        result_d[7:0] = dev_uo;
        state_d       = StRecvHi;
      end
      StRecvHi: begin
        result_d[15:8] = dev_uo;
        state_d        = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    dev_ena_d   = dev_active(state_d);
    dev_ui_d    = 8'h00;
    dev_uio_d   = 8'h00;
    if (state_d == StSendLo) begin
      dev_ui_d  = a_q[7:0];
      dev_uio_d = b_q[7:0];
    end else if (state_d == StSendHi) begin
      dev_ui_d  = a_q[15:8];
      dev_uio_d = b_q[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      dev_ena_q   <= 1'b0;
      dev_ui_q    <= 8'h00;
      dev_uio_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      dev_ena_q   <= dev_ena_d;
      dev_ui_q    <= dev_ui_d;
      dev_uio_q   <= dev_uio_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign dev_ena    = dev_ena_q;
  assign dev_ui     = dev_ui_q;
  assign dev_uio    = dev_uio_q;

`ifdef FP16_HOST_REF_CHECK_EN
  logic [15:0] expected;
  logic        chk_q, chk_d;

  fp16_mul_ref u_ref (
    .a    (a_q),
    .b    (b_q),
    .prod (expected)
  );

  // Compare against the result as it will stand in RESP, so the flag is valid on entry.
  assign chk_d = (state_d == StResp) && (result_d != expected);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_q <= 1'b0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chk_mismatch = chk_q;
`else
  assign chk_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_fp16_mul_byte_host.sv
// Self-checking bench for fp16_mul_byte_host with a cycle-counting device stub and FP16 model.
module tb_fp16_mul_byte_host;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, rsp_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  dev_uo;
  logic [7:0]  zero_byte = 8'h00;

  logic        req_ready, rsp_valid, dev_ena, chk_mismatch;
  logic [15:0] rsp_result;
  logic [7:0]  dev_ui, dev_uio;

  logic        x1_req_ready, x1_rsp_valid, x1_dev_ena, x1_chk;
  logic [15:0] x1_rsp_result;
  logic [7:0]  x1_dev_ui, x1_dev_uio;
  logic        x15_req_ready, x15_rsp_valid, x15_dev_ena, x15_chk;
  logic [15:0] x15_rsp_result;
  logic [7:0]  x15_dev_ui, x15_dev_uio;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  fp16_mul_byte_host #(.RESP_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .dev_ena(dev_ena), .dev_ui(dev_ui), .dev_uio(dev_uio),
    .dev_uo(dev_uo), .chk_mismatch(chk_mismatch)
  );

  fp16_mul_byte_host #(.RESP_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(x1_req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(x1_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(x1_rsp_result), .dev_ena(x1_dev_ena), .dev_ui(x1_dev_ui),
    .dev_uio(x1_dev_uio), .dev_uo(zero_byte), .chk_mismatch(x1_chk)
  );

  fp16_mul_byte_host #(.RESP_LAT(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(x15_req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(x15_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(x15_rsp_result), .dev_ena(x15_dev_ena), .dev_ui(x15_dev_ui),
    .dev_uio(x15_dev_uio), .dev_uo(zero_byte), .chk_mismatch(x15_chk)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of the device's product written in plain integer arithmetic.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ma, mb, ea, eb, m, c, e, mant;
    ma   = int'(a[9:0]);
    mb   = int'(b[9:0]);
    ea   = int'(a[14:10]);
    eb   = int'(b[14:10]);
    m    = ma + mb;
    c    = (m >= 1024) ? 1 : 0;
    e    = (ea + eb + 32 - 15 + c) % 32;
    mant = (c == 1) ? m / 2 : m;
    return {a[15] ^ b[15], e[4:0], mant[9:0]};
  endfunction

  function automatic logic exp_chk(input logic [15:0] stub, input logic [15:0] a,
                                   input logic [15:0] b);
`ifdef FP16_HOST_REF_CHECK_EN
    return stub != ref_mul(a, b);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 16'(req_ready), 16'd1);
    check({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd0);
    check({tag, "_rsp_result"}, rsp_result, 16'h0000);
    check({tag, "_dev_ena"}, 16'(dev_ena), 16'd0);
    check({tag, "_dev_bytes"}, {dev_ui, dev_uio}, 16'h0000);
    check({tag, "_chk"}, 16'(chk_mismatch), 16'd0);
  endtask

  // One full transaction: cycle 0 is the acceptance cycle; stub drives result bytes on RECV cycles.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] stub,
                         input int hold, input bit scramble);
    check("idle_req_ready", 16'(req_ready), 16'd1);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    cyc       = 0;
    step();
    req_valid = 1'b0;
    if (scramble) begin
      req_a = 16'($urandom);
      req_b = 16'($urandom);
    end
    check("sync_ena", 16'(dev_ena), 16'd1);
    check("sync_bytes", {dev_ui, dev_uio}, 16'h0000);
    check("sync_req_ready", 16'(req_ready), 16'd0);
    step();
    check("send_lo", {dev_ui, dev_uio}, {a[7:0], b[7:0]});
    step();
    check("send_hi", {dev_ui, dev_uio}, {a[15:8], b[15:8]});
    while (cyc < 5 + L) begin
      step();
      if (cyc == 4 + L) dev_uo = stub[7:0];
      if (cyc == 5 + L) dev_uo = stub[15:8];
      if (cyc < 4 + L) check("wait_bytes", {dev_ui, dev_uio}, 16'h0000);
      check("busy_ena", 16'(dev_ena), 16'd1);
      check("busy_rsp_valid", 16'(rsp_valid), 16'd0);
    end
    step();
    dev_uo = 8'h00;
    check("resp_valid_cycle", 16'(rsp_valid), 16'd1);
    check("resp_result", rsp_result, stub);
    check("resp_ena", 16'(dev_ena), 16'd0);
    check("resp_req_ready", 16'(req_ready), 16'd0);
    check("resp_chk", 16'(chk_mismatch), 16'(exp_chk(stub, a, b)));
    for (int i = 0; i < hold; i++) begin
      step();
      check("bp_valid", 16'(rsp_valid), 16'd1);
      check("bp_result", rsp_result, stub);
      check("bp_req_ready", 16'(req_ready), 16'd0);
      check("bp_ena", 16'(dev_ena), 16'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("post_req_ready", 16'(req_ready), 16'd1);
    check("post_rsp_valid", 16'(rsp_valid), 16'd0);
    check("post_result_held", rsp_result, stub);
    check("post_chk", 16'(chk_mismatch), 16'd0);
  endtask

  initial begin
    int f_m, f_1, f_15;
    bit saw_rsp;
    logic [15:0] ra, rb, stub;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a     = 16'h0;
    req_b     = 16'h0;
    dev_uo    = 8'h00;
    step();
    step();
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Latency for RESP_LAT = 3, 1, 15 on three instances fed the same request.
    f_m = -1; f_1 = -1; f_15 = -1;
    req_a = 16'h3C00; req_b = 16'h4000; req_valid = 1'b1; rsp_ready = 1'b1;
    cyc = 0;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (rsp_valid && f_m < 0) f_m = cyc;
      if (x1_rsp_valid && f_1 < 0) f_1 = cyc;
      if (x15_rsp_valid && f_15 < 0) f_15 = cyc;
      step();
    end
    check("lat_default", 16'(f_m), 16'd9);
    check("lat_1", 16'(f_1), 16'd7);
    check("lat_15", 16'(f_15), 16'd21);

    // Basic transfer, then backpressure.
    run_txn(16'h3C00, 16'h4000, 16'h4000, 0, 1'b0);
    run_txn(16'h3C00, 16'h4000, 16'h4000, 5, 1'b0);

    // Reference-check pair: wrong result first, then the correct one.
    run_txn(16'h3C00, 16'h4000, 16'h4001, 0, 1'b0);
    run_txn(16'h3C00, 16'h4000, 16'h4000, 0, 1'b0);

    // Random back-to-back traffic with input scrambling after acceptance.
    for (int k = 0; k < 8; k++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      stub = ref_mul(ra, rb);
      if (k % 3 == 2) stub = stub ^ 16'(1 << $urandom_range(0, 15));
      run_txn(ra, rb, stub, int'($urandom_range(0, 2)), 1'b1);
    end

    // Reset during WAIT aborts with no response.
    req_a = 16'h1234; req_b = 16'h5678; req_valid = 1'b1; rsp_ready = 1'b1;
    cyc = 0;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    saw_rsp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dev_uo = 8'hA5;
      step();
      if (rsp_valid) saw_rsp = 1'b1;
    end
    dev_uo = 8'h00;
    check("midreset_no_rsp", 16'(saw_rsp), 16'd0);
    check("midreset_idle", 16'(req_ready), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_mul_byte_host.md
Name: fp16_mul_byte_host

Overview:
- Host-side initiator for the byte-serial FP16 multiplier device port.
- Accepts one operand pair (two 16-bit half-precision words) over a valid/ready request interface.
- Serializes the pair low byte first onto the device's ui/uio buses, waits a fixed device latency, then deserializes the 2-byte result and returns it over a valid/ready response interface.
- Used in on-chip test harnesses and FPGA bring-up to drive the multiplier.

Parameters:
- RESP_LAT, 3, cycles in WAIT between SEND_HI and RECV_LO; legal range 1..15.
- DATA_W, 16, operand/result width; fixed at 16, byte count = DATA_W/8 = 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_a  in  16  operand A (FP16: sign[15], exp[14:10], mant[9:0])
- req_b  in  16  operand B
- rsp_valid  out  1  result valid, held until accepted
- rsp_ready  in  1  response accept
- rsp_result  out  16  assembled result
- dev_ena  out  1  device enable
- dev_ui  out  8  byte to device ui_in (operand A stream)
- dev_uio  out  8  byte to device uio_in (operand B stream)
- dev_uo  in  8  device uo_out (result stream)
- chk_mismatch  out  1  reference-check flag (see Optional Feature)

Behaviour:
- Reset: one clock, rst_n synchronous and active-low, sampled on posedge clk. When rst_n=0 at an edge:
  - state=IDLE;
  - req_ready=1 after reset release;
  - rsp_valid=0, rsp_result=0;
  - dev_ena=0, dev_ui=0, dev_uio=0;
  - chk_mismatch=0;
  - all internal registers cleared.
- Reset mid-operation aborts the transaction with no response. The device shares rst_n.
- All outputs are registered.
- FSM states: IDLE, SYNC, SEND_LO, SEND_HI, WAIT, RECV_LO, RECV_HI, RESP.
- IDLE: req_ready=1, dev_ena=0. On req_valid&&req_ready, capture req_a/req_b and go to SYNC. Request inputs are ignored after capture.
- SYNC (1 cycle): dev_ena=1, dev_ui/dev_uio=0. This gives the device its idle-to-collect cycle.
- SEND_LO: dev_ui=A[7:0], dev_uio=B[7:0].
- SEND_HI: dev_ui=A[15:8], dev_uio=B[15:8]. Load the wait counter with RESP_LAT-1.
- WAIT: dev_ena=1, bytes=0. Decrement the counter; exit to RECV_LO when it reaches 0.
- RECV_LO: sample dev_uo into result[7:0].
- RECV_HI: sample dev_uo into result[15:8]. Go to RESP.
- RESP: rsp_valid=1, rsp_result stable, dev_ena=0. On rsp_ready, go to IDLE.
- Timing: with request acceptance in cycle 0, rsp_valid first rises in cycle 6+RESP_LAT (9 at default). rsp_ready already high in that cycle completes the handshake the same cycle.
- Back-to-back: req_ready returns in the cycle after the response handshake. A request accepted then starts a fresh SYNC.
- dev_ena is 1 exactly in SYNC through RECV_HI.
- rsp_result holds its last value after the handshake until the next RECV_LO overwrites it.

Optional Feature:
- Macro: FP16_HOST_REF_CHECK_EN.
- When defined:
  - A combinational reference model computes the expected product from the captured A and B:
    - sign = Sa^Sb;
    - mantissa sum M = {1,Ma}+{1,Mb}, 11-bit wrap, carry C = M[10];
    - exponent = Ea+Eb-15+C, mod 32;
    - mantissa field = C ? M[10:1] : M[9:0].
  - In RESP, chk_mismatch=1 iff rsp_result differs from the expected value. The flag clears on leaving RESP.
- When not defined: chk_mismatch is tied 0 and no model logic is synthesized.

Decomposition:
- fp16_host_pkg holds:
  - state enum;
  - FP16 field widths/offsets (SIGN_BIT=15, EXP_MSB=14, EXP_LSB=10, MANT_W=10);
  - EXP_BIAS=15;
  - BYTES=2.
- One sub-module: fp16_mul_ref (pure combinational reference), instantiated only under FP16_HOST_REF_CHECK_EN.

Test Plan:
- Basic transfer:
  - Stimulus: req_a=0x3C00, req_b=0x4000; device stub returns 0x4000 (byte 0x00 at RECV_LO, 0x40 at RECV_HI).
  - Required: dev_ui 0x00 then 0x3C and dev_uio 0x00 then 0x40 in SEND_LO/SEND_HI; rsp_valid in cycle 9; rsp_result=0x4000.
- Backpressure:
  - Stimulus: rsp_ready held 0 for 5 cycles after rsp_valid.
  - Required: rsp_valid and rsp_result stay stable; req_ready=0; dev_ena=0 throughout; IDLE one cycle after rsp_ready=1.
- Input isolation and back-to-back:
  - Stimulus: change req_a/req_b after acceptance, then issue a second request immediately.
  - Required: captured bytes are unchanged; the second SYNC starts exactly 1 cycle after the first handshake.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle during WAIT.
  - Required: next cycle all outputs are at reset values with req_ready=1; no response is ever produced.
- Latency parameter:
  - Stimulus: RESP_LAT=1 and RESP_LAT=15.
  - Required: rsp_valid in cycle 7 and cycle 21 respectively.
- Reference check (FP16_HOST_REF_CHECK_EN defined):
  - Stimulus: stub returns 0x4001 for 0x3C00×0x4000, then 0x4000 for the same pair.
  - Required: chk_mismatch=1 in RESP for the first transaction and 0 for the second.
